// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with packet lock,
// forced-select bypass and one registered output stage.
// Optional feature macro: STREAM_MUX_RR_EN selects round-robin arbitration.
// Without it, the lowest valid channel index wins and no rr pointer exists.
module stream_mux_rr #(
    parameter int  nBit = 8,
    parameter int  nCh  = 8,
    localparam int SelW = $clog2(nCh)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [nCh*nBit-1:0] in_data,
    input  logic [nCh-1:0]      in_valid,
    input  logic [nCh-1:0]      in_last,
    output logic [nCh-1:0]      in_ready,
    input  logic                force_en,
    input  logic [SelW-1:0]     force_sel,
    output logic [nBit-1:0]     out_data,
    output logic                out_last,
    output logic [SelW-1:0]     out_sel,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [SelW-1:0] lock_ch_q, lock_ch_d;
    logic [nBit-1:0] ch_data [nCh];
    logic [SelW-1:0] gnt, idx;
    logic            gnt_vld, load, xfer;

    logic            out_valid_q, out_valid_d;
    logic [nBit-1:0] out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [SelW-1:0] out_sel_q, out_sel_d;

`ifdef STREAM_MUX_RR_EN
    logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
`endif

    for (genvar c = 0; c < nCh; c++) begin : g_unpack
        assign ch_data[c] = in_data[c*nBit +: nBit];
    end

    // Output register takes a new beat when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;
    assign xfer = gnt_vld && load && in_valid[gnt];

    // Grant: lock owner wins, then forced select, then arbitration.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        if (state_q == ST_LOCKED) begin
            gnt     = lock_ch_q;
            gnt_vld = 1'b1;
        end else if (force_en) begin
            if (int'(force_sel) < nCh) begin
                gnt     = force_sel;
                gnt_vld = 1'b1;
            end
        end else begin
`ifdef STREAM_MUX_RR_EN
            // Walk backwards so the earliest hit after rr_ptr is the final write.
            for (int k = nCh; k >= 1; k--) begin
                idx = SelW'((int'(rr_ptr_q) + k) % nCh);
                if (in_valid[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
`else
            for (int i = nCh - 1; i >= 0; i--) begin
                idx = SelW'(i);
                if (in_valid[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
`endif
        end
    end

    // Ready goes only to the granted channel, independent of its own valid.
    always_comb begin
        in_ready = '0;
        if (gnt_vld && load) in_ready = nCh'(1) << gnt;
    end

    // Output stage next state: capture on transfer, drop valid when drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt];
            out_last_d  = in_last[gnt];
            out_sel_d   = gnt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Packet lock: enter on a non-last beat, leave on the owner's last beat.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            if (state_q == ST_UNLOCKED && !in_last[gnt]) begin
                state_d   = ST_LOCKED;
                lock_ch_d = gnt;
            end else if (state_q == ST_LOCKED && in_last[gnt]) begin
                state_d = ST_UNLOCKED;
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Pointer follows the winner of each unlocked transfer only.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && state_q == ST_UNLOCKED) rr_ptr_d = gnt;
    end

    // Pointer register; reset to nCh-1 so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= SelW'(nCh - 1);
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    // State and output registers; reset drops any lock and held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            lock_ch_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus randomized traffic against
// a packet-level reference model (owner channel, last winner, output beat).
module tb_stream_mux_rr;
    localparam int nBit = 8;
    localparam int nCh  = 8;
    localparam int SelW = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [nCh*nBit-1:0] in_data = '0;
    logic [nCh-1:0]      in_valid = '0;
    logic [nCh-1:0]      in_last = '0;
    logic [nCh-1:0]      in_ready;
    logic                force_en = 1'b0;
    logic [SelW-1:0]     force_sel = '0;
    logic [nBit-1:0]     out_data;
    logic                out_last;
    logic [SelW-1:0]     out_sel;
    logic                out_valid;
    logic                out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.nBit(nBit), .nCh(nCh)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .force_en(force_en), .force_sel(force_sel),
        .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Reference model: the beat sitting in the output register, the channel
    // owning an open packet (-1 if none) and the last unlocked winner.
    logic            m_v;
    logic [nBit-1:0] m_d;
    logic            m_l;
    logic [SelW-1:0] m_s;
    int              m_owner;
    int              m_rr;

    task automatic model_reset();
        m_v = 1'b0; m_d = '0; m_l = 1'b0; m_s = '0;
        m_owner = -1;
        m_rr = nCh - 1;
    endtask

    function automatic int exp_grant();
        if (m_owner >= 0) return m_owner;
        if (force_en) return (int'(force_sel) < nCh) ? int'(force_sel) : -1;
`ifdef STREAM_MUX_RR_EN
        for (int k = 1; k <= nCh; k++)
            if (in_valid[(m_rr + k) % nCh]) return (m_rr + k) % nCh;
`else
        for (int i = 0; i < nCh; i++)
            if (in_valid[i]) return i;
`endif
        return -1;
    endfunction

    function automatic logic [nCh-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g >= 0 && (!m_v || out_ready)) return nCh'(1) << g;
        return '0;
    endfunction

    task automatic model_clock();
        int g;
        g = exp_grant();
        if (g >= 0 && (!m_v || out_ready) && in_valid[g]) begin
            if (m_owner < 0) m_rr = g;
            m_owner = in_last[g] ? -1 : g;
            m_v = 1'b1;
            m_d = in_data[g*nBit +: nBit];
            m_l = in_last[g];
            m_s = SelW'(g);
        end else if (out_ready) begin
            m_v = 1'b0;
        end
    endtask

    // Advance one clock; inputs stay stable across the rising edge.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0;
        force_en = 1'b0; force_sel = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_data, out_last, out_sel} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d want all 0",
                     out_valid, out_data, out_last, out_sel);
        end
        n_vec++;
        if (in_ready !== '0) begin
            n_err++;
            $display("FAIL reset_ready: got %h want 00", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        in_valid = 8'h04; in_last = '1; in_data = '0; in_data[2*nBit +: nBit] = 8'hA5;
        out_ready = 1'b1; force_en = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 8'h04) begin
            n_err++;
            $display("FAIL single_ready: got %h want 04", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_vec++;
        if ({out_valid, out_data, out_sel, out_last} !== {1'b1, 8'hA5, 3'd2, 1'b1}) begin
            n_err++;
            $display("FAIL single_out: got v=%b d=%h s=%0d l=%b want v=1 d=a5 s=2 l=1",
                     out_valid, out_data, out_sel, out_last);
        end
        tick();
    endtask

    task automatic test_rr_fairness();
        int want;
        do_reset();
        in_valid = '1; in_last = '1; out_ready = 1'b1; force_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_data = {$urandom, $urandom};
            #1;
            n_vec++;
            if (in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rr_ready cyc%0d: got %h want %h", c, in_ready, exp_ready());
            end
            if (c >= 1) begin
`ifdef STREAM_MUX_RR_EN
                want = (c - 1) % nCh;
`else
                want = 0;
`endif
                n_vec++;
                if (out_valid !== 1'b1 || int'(out_sel) != want || out_data !== m_d) begin
                    n_err++;
                    $display("FAIL rr_sel cyc%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                             c, out_valid, out_sel, out_data, want, m_d);
                end
            end
            tick();
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] vld_t [4] = '{8'h0A, 8'h2A, 8'h2A, 8'h02};
        logic       fen_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int         fsl_t [4] = '{3, 5, 5, 0};
        logic       lst_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int         sel_t [4] = '{3, 3, 3, 1};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                in_valid = vld_t[c]; force_en = fen_t[c]; force_sel = SelW'(fsl_t[c]);
                in_last = 8'h02 | (8'(lst_t[c]) << 3);
                in_data = {$urandom, $urandom};
            end else begin
                in_valid = '0; force_en = 1'b0;
            end
            #1;
            if (c < 4) begin
                n_vec++;
                if (in_ready !== (8'h01 << sel_t[c]) || in_ready !== exp_ready()) begin
                    n_err++;
                    $display("FAIL lock_ready cyc%0d: got %h want %h", c, in_ready, 8'h01 << sel_t[c]);
                end
            end
            if (c >= 1) begin
                n_vec++;
                if (out_valid !== 1'b1 || int'(out_sel) != sel_t[c-1]) begin
                    n_err++;
                    $display("FAIL lock_sel cyc%0d: got v=%b s=%0d want v=1 s=%0d",
                             c, out_valid, out_sel, sel_t[c-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic       rdy_t [12] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic [7:0] nxt = 8'h10;
        logic [7:0] sent [$];
        logic [7:0] rcv [$];
        force_en = 1'b0; in_last = '1;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c < 12) ? rdy_t[c] : 1'b1;
            in_valid  = (c < 12) ? 8'h10 : 8'h00;
            in_data = '0; in_data[4*nBit +: nBit] = nxt;
            #1;
            n_vec++;
            if (in_ready !== exp_ready() || {out_valid, out_data} !== {m_v, m_d}) begin
                n_err++;
                $display("FAIL bp_model cyc%0d: got r=%h v=%b d=%h want r=%h v=%b d=%h",
                         c, in_ready, out_valid, out_data, exp_ready(), m_v, m_d);
            end
            if (c >= 3 && c <= 6) begin
                n_vec++;
                if (in_ready !== '0 || out_valid !== 1'b1 || out_data !== sent[$]) begin
                    n_err++;
                    $display("FAIL bp_stall cyc%0d: got r=%h v=%b d=%h want r=00 v=1 d=%h",
                             c, in_ready, out_valid, out_data, sent[$]);
                end
            end
            if (out_valid && out_ready) rcv.push_back(out_data);
            if (in_valid[4] && in_ready[4]) begin
                sent.push_back(nxt);
                nxt++;
            end
            tick();
        end
        n_vec++;
        if (rcv.size() != sent.size() || sent.size() != 8) begin
            n_err++;
            $display("FAIL bp_count: got rcv=%0d sent=%0d want 8 each", rcv.size(), sent.size());
        end
        for (int i = 0; i < rcv.size() && i < sent.size(); i++) begin
            n_vec++;
            if (rcv[i] !== 8'(8'h10 + i)) begin
                n_err++;
                $display("FAIL bp_order beat%0d: got %h want %h", i, rcv[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_force();
        force_en = 1'b1; force_sel = 3'd6; in_valid = 8'h41; in_last = '1;
        in_data = {$urandom, $urandom}; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 8'h40) begin
            n_err++;
            $display("FAIL force_ready: got %h want 40", in_ready);
        end
        tick();
        in_valid = 8'h01;
        #1;
        n_vec++;
        if (in_ready !== 8'h40 || out_sel !== 3'd6 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL force_hold: got r=%h s=%0d v=%b want r=40 s=6 v=1", in_ready, out_sel, out_valid);
        end
        tick();
        in_valid = '0; force_en = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL force_notx: got v=%b want v=0", out_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        force_en = 1'b1; force_sel = 3'd2; in_valid = 8'h04; in_last = '0;
        in_data = {$urandom, $urandom}; out_ready = 1'b0;
        #1;
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({out_valid, out_data, out_last, out_sel} !== '0) begin
            n_err++;
            $display("FAIL areset_out: got v=%b d=%h l=%b s=%0d want all 0",
                     out_valid, out_data, out_last, out_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        force_en = 1'b0; in_valid = '1; in_last = '1; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 8'h01) begin
            n_err++;
            $display("FAIL areset_ready: got %h want 01", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_sel !== 3'd0) begin
            n_err++;
            $display("FAIL areset_first: got v=%b s=%0d want v=1 s=0", out_valid, out_sel);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 8'($urandom);
            in_last   = 8'($urandom);
            in_data   = {$urandom, $urandom};
            force_en  = ($urandom_range(0, 9) == 0);
            force_sel = SelW'($urandom_range(0, nCh - 1));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_vec++;
            if (in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready cyc%0d: got %h want %h", c, in_ready, exp_ready());
            end
            n_vec++;
            if ({out_valid, out_data, out_last, out_sel} !== {m_v, m_d, m_l, m_s}) begin
                n_err++;
                $display("FAIL rand_out cyc%0d: got v=%b d=%h l=%b s=%0d want v=%b d=%h l=%b s=%0d",
                         c, out_valid, out_data, out_last, out_sel, m_v, m_d, m_l, m_s);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_beat();
        test_rr_fairness();
        test_packet_lock();
        test_backpressure();
        test_force();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with valid/ready handshakes on every input and the output. It is the successor to the combinational 8:1 selector used in the SPRINT datapaths. It arbitrates among requesting channels, either round-robin or fixed-priority, or uses a forced channel select. It locks onto a channel until the end of a multi-beat packet and presents the winning beat through a single registered output stage. It sits between several producer blocks and one shared consumer, for example a display or UART path.

## Interface
- nBit, 8, data width per channel (≥1)
- nCh, 8, number of input channels (2..16); SelW = $clog2(nCh) is derived, not overridable
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  nCh*nBit  channel i occupies bits [i*nBit +: nBit]
- in_valid  in  nCh  per-channel beat valid
- in_last  in  nCh  per-channel end-of-packet marker, qualified by in_valid
- in_ready  out  nCh  per-channel accept; combinational
- force_en  in  1  when 1, bypass arbitration and use force_sel
- force_sel  in  SelW  forced channel index
- out_data  out  nBit  registered output beat
- out_last  out  1  registered last marker
- out_sel  out  SelW  source channel of the current out_data
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accept

## Operation
- Transfer on input i: in_valid[i] && in_ready[i]. Transfer on output: out_valid && out_ready.
- load = !out_valid || out_ready. The output register accepts a new beat only when load = 1.
- Grant g is computed combinationally each cycle:
  - LOCKED state: g = lock_ch.
  - UNLOCKED with force_en = 1: g = force_sel. If force_sel ≥ nCh, there is no grant.
  - UNLOCKED with force_en = 0: arbitration over in_valid (see Configuration).
- in_ready[i] = (i == g) && grant_valid && load. All other in_ready bits are 0. in_ready never depends on in_valid[i] of the same channel.
- On input transfer: out_data ← in_data[g], out_last ← in_last[g], out_sel ← g, out_valid ← 1.
- Without an input transfer: if out_ready, out_valid ← 0. Otherwise all output registers hold.
- State machine, two states:
  - UNLOCKED → LOCKED (lock_ch ← g) on a transfer with in_last[g] = 0.
  - LOCKED → UNLOCKED on a transfer from lock_ch with in_last = 1.
  - A single-beat packet (last = 1 on an UNLOCKED transfer) stays UNLOCKED.
- While LOCKED, force_en/force_sel and other channels' valids are ignored. If lock_ch is not valid, no transfer occurs and the lock is held (no timeout).
- Round-robin pointer rr_ptr updates to g on every UNLOCKED transfer only.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid = 0, out_data = 0, out_last = 0, out_sel = 0
  - state = UNLOCKED, lock_ch = 0, rr_ptr = nCh-1, so channel 0 is searched first
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: one beat per cycle when out_ready is held at 1.
- Backpressure: out_ready = 0 with out_valid = 1 holds out_data/out_last/out_sel stable and drives all in_ready to 0.
- Reset mid-packet drops the lock and any held output beat. No partial beat survives.
- Simultaneous output drain and input accept in the same cycle is a legal back-to-back transfer.

## Configuration
- STREAM_MUX_RR_EN defined: round-robin arbitration. The search starts at rr_ptr+1, wraps modulo nCh, and grants the first channel with in_valid set.
- Undefined: fixed priority, lowest valid index wins. rr_ptr is not implemented, and output/port behaviour is otherwise identical.

## Test plan
- Reset, then single beat: hold rst_n = 0 and check all outputs are 0. Release, drive in_valid = 8'h04, in_data ch2 = 8'hA5, last = 1, out_ready = 1. Require in_ready = 8'h04, and next cycle out_valid = 1, out_data = A5, out_sel = 2, out_last = 1.
- Round-robin fairness (RR_EN): hold in_valid = 8'hFF, all last = 1, out_ready = 1. Require out_sel sequence 0,1,2,…,7,0. Without the macro, require out_sel = 0 every cycle.
- Packet lock: ch3 sends 3 beats (last on beat 3) while ch1 stays valid. Require out_sel = 3,3,3 consecutively, then 1. force_en = 1 with force_sel = 5 mid-packet has no effect.
- Backpressure: out_ready = 0 for 4 cycles with out_valid = 1. Require out_data unchanged and in_ready = 0. Release and require no beat lost or duplicated.
- Force select: force_en = 1, force_sel = 6, in_valid = 8'h41. Require only in_ready[6]. With force_sel = 6 and in_valid = 8'h01, require no transfer.
- Async reset while LOCKED with a held beat: require out_valid = 0 immediately. After release, ch0 is granted first.
